// File: rtl/game_countdown_timer_if.sv
// Control/status bundle between the game FSM and the round countdown timer.
// The game FSM holds the master side; the timer implements the slave side.
interface game_countdown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  start_i;
  logic                  pause_i;
  logic                  load_i;
  logic [4*DIGITS-1:0]   load_val_i;
  logic                  running_o;
  logic                  expired_o;
  logic                  done_o;
  logic [4*DIGITS-1:0]   bcd_o;
  logic [7*DIGITS-1:0]   seg_o;

  modport master (
    output start_i, pause_i, load_i, load_val_i,
    input  running_o, expired_o, done_o, bcd_o, seg_o
  );

  modport slave (
    input  start_i, pause_i, load_i, load_val_i,
    output running_o, expired_o, done_o, bcd_o, seg_o
  );
endinterface

// File: rtl/game_countdown_timer.sv
// BCD round clock for whack-a-mole: counts down one step every TICK_DIV cycles,
// supports pause/resume, runtime load and restart, and drives 7-segment digits.
module game_countdown_timer #(
  parameter int                  TICK_DIV    = 50_000_000,
  parameter int                  DIGITS      = 2,
  parameter logic [4*DIGITS-1:0] START_VAL   = 'h20,
  parameter bit                  SEG_ACT_LOW = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  game_countdown_timer_if.slave bus
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                done_q, done_d;
  logic                advance;
  logic [4*DIGITS-1:0] bcdDec;
  logic [7*DIGITS-1:0] seg;

  // Any digit above 9 saturates to 9 so the display never shows garbage.
  function automatic logic [4*DIGITS-1:0] clampBcd(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] decBcd(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low gfedcba patterns; blank for anything that is not a decimal digit.
  function automatic logic [6:0] segCode(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0011000;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  // State, count, prescaler and the expiry pulse all reset asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_q   <= START_VAL;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  // A zero count never wraps: stepping from zero stays at zero.
  assign bcdDec = (bcd_q == '0) ? '0 : decBcd(bcd_q);

  // Commands resolve as load > start > pause > tick.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    advance = 1'b0;

    if (bus.load_i) begin
      bcd_d   = clampBcd(bus.load_val_i);
      presc_d = '0;
      state_d = IDLE;
    end else if (bus.start_i && (state_q == IDLE)) begin
      presc_d = '0;
      if (bcd_q == '0) begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (bus.start_i && (state_q == EXPIRED)) begin
      bcd_d   = START_VAL;
      presc_d = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.pause_i) state_d = PAUSED;
          else             advance = 1'b1;
        end
        PAUSED: begin
          if (!bus.pause_i) begin
            state_d = RUN;
            advance = 1'b1;
          end
        end
        default: ;
      endcase

      // Resuming counts on the release cycle, continuing from the held prescaler.
      if (advance) begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          bcd_d   = bcdDec;
          if (bcdDec == '0) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
  end

  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = SEG_ACT_LOW ? segCode(bcd_q[4*i +: 4]) : ~segCode(bcd_q[4*i +: 4]);
    end
  end

  assign bus.running_o = (state_q == RUN);
  assign bus.expired_o = (state_q == EXPIRED);
  assign bus.done_o    = done_q;
  assign bus.bcd_o     = bcd_q;
  assign bus.seg_o     = seg;

endmodule
